// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - Immediate generator with buffered output queue; optional CSR zimm via IMMGEN_CSR_EN
module imm_gen_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [2:0]            ImmSrc,
    input  logic [ADDR_WIDTH-1:0] PC,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] ImmExt,
    output logic [ADDR_WIDTH-1:0] PC_out,
    output logic                  illegal,
    output logic [ILL_CNT_W-1:0]  ill_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] r_imm_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem  [DEPTH];
    logic                  r_ill_mem [DEPTH];

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ILL_CNT_W-1:0]  r_ill_cnt;

    logic [31:0]           w_imm32;
    logic                  w_ill;
    logic [ADDR_WIDTH-1:0] w_imm_ext;
    logic                  w_push;
    logic                  w_pop;

    // Decode the immediate for the incoming instruction; zimm has bit 31 clear so sign fill is a zero fill
    always_comb begin
        w_imm32 = 32'h0;
        w_ill   = 1'b0;
        case (ImmSrc)
            3'b000: w_imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: w_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: w_imm32 = {instr[31:12], 12'h000};
            3'b100: w_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMMGEN_CSR_EN
            3'b101: w_imm32 = {27'h0, instr[19:15]};
`endif
            default: begin
                w_imm32 = 32'h0;
                w_ill   = 1'b1;
            end
        endcase
    end

    assign w_imm_ext = ADDR_WIDTH'($signed(w_imm32));

    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign ImmExt  = out_valid ? r_imm_mem[r_rd_ptr] : '0;
    assign PC_out  = out_valid ? r_pc_mem[r_rd_ptr]  : '0;
    assign illegal = out_valid ? r_ill_mem[r_rd_ptr] : 1'b0;
    assign ill_cnt = r_ill_cnt;

    // Store the decoded entry at the write pointer; stale slots are masked by count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm_mem[r_wr_ptr] <= w_imm_ext;
            r_pc_mem[r_wr_ptr]  <= PC;
            r_ill_mem[r_wr_ptr] <= w_ill;
        end
    end

    // Queue bookkeeping: reset beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Saturating count of accepted illegal entries; flush does not rewind it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ill_cnt <= '0;
        end else if (w_push && w_ill && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - Self-checking bench for imm_gen_pipe against a queue reference model
module tb_imm_gen_pipe;

    localparam int AW    = 32;
    localparam int DEPTH = 2;
    localparam int ICW   = 2;
    localparam int ISAT  = (1 << ICW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic [2:0]    ImmSrc;
    logic [AW-1:0] PC;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] ImmExt;
    logic [AW-1:0] PC_out;
    logic          illegal;
    logic [ICW-1:0] ill_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] pc;
        bit          ill;
    } ent_t;

    ent_t q[$];
    int   m_ill = 0;

    imm_gen_pipe #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .ILL_CNT_W(ICW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .ImmSrc    (ImmSrc),
        .PC        (PC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ImmExt    (ImmExt),
        .PC_out    (PC_out),
        .illegal   (illegal),
        .ill_cnt   (ill_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode built from bit fields and a sign mask
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, output bit ill);
        logic [31:0] sm;
        sm  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        ill = 1'b0;
        case (src)
            3'd0: ref_imm = (sm & 32'hFFFF_F800) | 32'(ins[30:20]);
            3'd1: ref_imm = (sm & 32'hFFFF_F800) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
            3'd2: ref_imm = (sm & 32'hFFFF_F000) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            3'd3: ref_imm = ins & 32'hFFFF_F000;
            3'd4: ref_imm = (sm & 32'hFFF0_0000) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
`ifdef IMMGEN_CSR_EN
            3'd5: ref_imm = 32'(ins[19:15]);
`endif
            default: begin
                ref_imm = 32'h0;
                ill     = 1'b1;
            end
        endcase
    endfunction

    // One clock: predict from current inputs, advance, then compare every output
    task automatic cycle();
        bit          push;
        bit          pop;
        bit          ill;
        logic [31:0] imm;
        ent_t        e;
        push = rst_n && in_valid && (q.size() < DEPTH);
        pop  = out_ready && (q.size() != 0);
        imm  = ref_imm(instr, ImmSrc, ill);
        e.imm = imm;
        e.pc  = PC;
        e.ill = ill;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            m_ill = 0;
        end else begin
            if (push && ill && m_ill < ISAT) m_ill++;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) q.delete(0);
                if (push) q.push_back(e);
            end
        end
        chk("in_ready",  in_ready,  q.size() < DEPTH);
        chk("out_valid", out_valid, q.size() != 0);
        chk("ImmExt",    ImmExt,    q.size() != 0 ? q[0].imm : 32'h0);
        chk("PC_out",    PC_out,    q.size() != 0 ? q[0].pc  : 32'h0);
        chk("illegal",   illegal,   q.size() != 0 ? q[0].ill : 1'b0);
        chk("ill_cnt",   ill_cnt,   m_ill);
    endtask

    logic [31:0] vec_ins [5];
    logic [31:0] vec_exp [5];

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; ImmSrc = 3'd0; PC = 32'h0;
        #1;
        cycle();
        rst_n = 1'b1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready",  in_ready,  1'b1);
        cycle();

        // Golden format vectors, each into an empty buffer
        vec_ins[0] = 32'hFFF00093; vec_exp[0] = 32'hFFFFFFFF;
        vec_ins[1] = 32'hFE112E23; vec_exp[1] = 32'hFFFFFFFC;
        vec_ins[2] = 32'hFE000CE3; vec_exp[2] = 32'hFFFFFFF8;
        vec_ins[3] = 32'h123452B7; vec_exp[3] = 32'h12345000;
        vec_ins[4] = 32'h001000EF; vec_exp[4] = 32'h00000800;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; instr = vec_ins[i]; ImmSrc = 3'(i); PC = 32'h1000 + 32'(i * 4);
            cycle();
            in_valid = 1'b0;
            chk("golden_valid", out_valid, 1'b1);
            chk("golden_imm", ImmExt, vec_exp[i]);
            cycle();
        end

        // Back-pressure: third push refused, order preserved on drain
        out_ready = 1'b0; ImmSrc = 3'd0; in_valid = 1'b1;
        PC = 32'hA0; cycle();
        PC = 32'hA1; cycle();
        chk("full_in_ready", in_ready, 1'b0);
        PC = 32'hA2; cycle();
        in_valid = 1'b0; out_ready = 1'b1;
        chk("order_pc0", PC_out, 32'hA0);
        cycle();
        chk("order_pc1", PC_out, 32'hA1);
        chk("ready_after_pop", in_ready, 1'b1);
        cycle();
        chk("drained", out_valid, 1'b0);

        // Flush while full with a concurrent push
        out_ready = 1'b0; in_valid = 1'b1;
        PC = 32'hB0; cycle();
        PC = 32'hB1; cycle();
        flush = 1'b1; PC = 32'hB2; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_pc", PC_out, 32'h0);
        cycle();

        // Illegal encodings and counter saturation
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; ImmSrc = 3'd7;
        for (int i = 0; i < 5; i++) begin
            instr = $urandom; PC = 32'hC0 + 32'(i);
            cycle();
            chk("ill_flag", illegal, 1'b1);
            chk("ill_imm", ImmExt, 32'h0);
        end
        in_valid = 1'b0;
        cycle();
        chk("ill_sat", ill_cnt, 2'd3);

        // CSR zimm format
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        in_valid = 1'b1; ImmSrc = 3'd5; instr = 32'h000F8073; PC = 32'hD0;
        cycle();
        in_valid = 1'b0;
`ifdef IMMGEN_CSR_EN
        chk("zimm_imm", ImmExt, 32'h1F);
        chk("zimm_ill", illegal, 1'b0);
        chk("zimm_cnt", ill_cnt, 2'd0);
`else
        chk("zimm_imm", ImmExt, 32'h0);
        chk("zimm_ill", illegal, 1'b1);
        chk("zimm_cnt", ill_cnt, 2'd1);
`endif
        cycle();

        // Reset with two entries buffered
        out_ready = 1'b0; in_valid = 1'b1; ImmSrc = 3'd6;
        PC = 32'hE0; cycle();
        PC = 32'hE1; cycle();
        in_valid = 1'b0; rst_n = 1'b0; cycle(); rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_ill_cnt", ill_cnt, 2'd0);
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            instr     = $urandom;
            ImmSrc    = 3'($urandom % 8);
            PC        = $urandom;
            flush     = ($urandom % 25) == 0;
            rst_n     = ($urandom % 80) != 0;
            cycle();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the immediate and PC width; legal values 32 or 64; all bits above the format's sign bit SHALL be sign-filled.
REQ-002 Parameter DEPTH, default 2, SHALL set output buffer entries; power of two, >=2.
REQ-003 Parameter ILL_CNT_W, default 8, SHALL set the illegal-encoding counter width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-006 flush  in  1  discards all buffered entries.
REQ-007 in_valid  in  1  upstream entry valid.
REQ-008 in_ready  out  1  entry can be accepted.
REQ-009 instr  in  32  raw instruction word.
REQ-010 ImmSrc  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 CSR zimm, 110/111 reserved.
REQ-011 PC  in  ADDR_WIDTH  tag carried unchanged with the entry.
REQ-012 out_valid  out  1  head entry valid.
REQ-013 out_ready  in  1  downstream consumes the head entry.
REQ-014 ImmExt  out  ADDR_WIDTH  extended immediate of the head entry.
REQ-015 PC_out  out  ADDR_WIDTH  PC tag of the head entry.
REQ-016 illegal  out  1  head entry had an unsupported ImmSrc.
REQ-017 ill_cnt  out  ILL_CNT_W  saturating count of accepted illegal entries.

Function
REQ-018 Push SHALL occur when in_valid and in_ready; pop SHALL occur when out_valid and out_ready.
REQ-019 The immediate SHALL be computed at push and stored in the buffer, giving latency 1: an entry pushed in cycle N SHALL appear at the head in cycle N+1 when the buffer was empty.
REQ-020 I: instr[31:20]; S: {instr[31:25],instr[11:7]}; B: {instr[31],instr[7],instr[30:25],instr[11:8],0}; U: {instr[31:12],12'b0}; J: {instr[31],instr[19:12],instr[20],instr[30:21],0}. Each SHALL be sign-extended from instr[31] to ADDR_WIDTH.
REQ-021 Reserved ImmSrc SHALL store ImmExt=0 and illegal=1; legal formats SHALL store illegal=0.
REQ-022 in_ready SHALL equal (count < DEPTH), with no combinational path from out_ready.
REQ-023 out_valid SHALL equal (count != 0); ImmExt, PC_out and illegal SHALL be 0 when empty.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 When full, no push SHALL occur and in_ready SHALL return high the cycle after a pop.
REQ-026 A pop when empty SHALL have no effect.
REQ-027 flush SHALL set count and pointers to 0 next cycle and SHALL discard any same-cycle push and pop; ill_cnt SHALL be unaffected.
REQ-028 ill_cnt SHALL increment on each pushed illegal entry, including entries later flushed, and SHALL saturate at all-ones.

Reset
REQ-029 rst_n low at a clock edge SHALL clear count, pointers and ill_cnt; out_valid=0, in_ready=1, and ImmExt=PC_out=illegal=0 in the following cycle.
REQ-030 Reset SHALL take priority over flush, push and pop; buffered contents during reset mid-operation SHALL be discarded.

Configuration
REQ-031 With macro IMMGEN_CSR_EN defined, ImmSrc 101 SHALL produce zero-extended instr[19:15] with illegal=0; without it, 101 SHALL be treated as reserved per REQ-021.

Verification
REQ-032 Each case pushed into the empty buffer, ADDR_WIDTH=32, out_ready=1 -> next cycle head: I 0xFFF00093 -> 0xFFFFFFFF; S 0xFE112E23 -> 0xFFFFFFFC; B 0xFE000CE3 -> 0xFFFFFFF8; U 0x123452B7 -> 0x12345000; J 0x001000EF -> 0x00000800.
REQ-033 DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready low after the second push, third not accepted; raise out_ready -> PCs emerge in push order, one per cycle.
REQ-034 Buffer full, flush with simultaneous in_valid=1 -> next cycle out_valid=0, count 0, pushed entry absent.
REQ-035 ILL_CNT_W=2, five pushes with ImmSrc 111 -> each head shows illegal=1 and ImmExt=0; ill_cnt ends at 3.
REQ-036 ImmSrc 101, instr[19:15]=5'h1F -> ImmExt 0x0000001F with IMMGEN_CSR_EN defined; illegal=1, ImmExt 0 and ill_cnt+1 without it.
REQ-037 rst_n low for one cycle with 2 entries buffered -> next cycle out_valid=0, in_ready=1, ill_cnt=0.
